// File: rtl/rx_dly_scan_ctrl_pkg.sv
// Shared types and constants for the RX input-delay scan controller.
// Holds the FSM state encoding and the tap-centre helper used by the top.
package rx_dly_scan_ctrl_pkg;

  localparam int unsigned DLY_TAPS_DEF = 32;
  localparam int unsigned TAP_W        = 5;
  localparam logic [7:0]  ERR_SAT      = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    DWELL,
    EVAL,
    SELECT,
    APPLY,
    DONE_ST
  } state_t;

  // Centre of a passing run; the lower middle tap is chosen for even lengths.
  function automatic logic [TAP_W-1:0] window_center(input logic [TAP_W-1:0] run_start,
                                                     input logic [5:0]       len);
    logic [5:0] off;
    off = (len - 6'd1) >> 1;
    return run_start + off[TAP_W-1:0];
  endfunction

endpackage

// File: rtl/rx_dly_window_find.sv
// Serial longest-run search over a stream of pass bits, one bit per cycle.
// Strictly-longer runs replace the best, so the lowest-index run wins ties.
module rx_dly_window_find
  import rx_dly_scan_ctrl_pkg::*;
#(
  parameter int unsigned TAPS = DLY_TAPS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [TAP_W-1:0] run_start,
  output logic [5:0]       len,
  output logic             valid
);

  logic [TAP_W-1:0] idx;
  logic [TAP_W-1:0] cur_start;
  logic [5:0]       cur_len;
  logic [5:0]       ext_len;
  logic [TAP_W-1:0] run_begin;

  always_comb begin
    ext_len   = cur_len + 6'd1;
    run_begin = (cur_len == '0) ? idx : cur_start;
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      idx       <= '0;
      cur_start <= '0;
      cur_len   <= '0;
      run_start <= '0;
      len       <= '0;
      valid     <= 1'b0;
    end else if (bit_valid) begin
      idx   <= idx + TAP_W'(1);
      valid <= (idx == TAP_W'(TAPS - 1));
      if (bit_in) begin
        cur_len   <= ext_len;
        cur_start <= run_begin;
        if (ext_len > len) begin
          len       <= ext_len;
          run_start <= run_begin;
        end
      end else begin
        cur_len <= '0;
      end
    end
  end

endmodule

// File: rtl/rx_dly_scan_ctrl.sv
// RX input-delay scan: steps every tap, judges link health per tap, then
// loads the centre of the longest passing window (or the original delay).
module rx_dly_scan_ctrl
  import rx_dly_scan_ctrl_pkg::*;
#(
  parameter int unsigned DLY_TAPS = DLY_TAPS_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST,
  input  logic                START,
  input  logic                ABORT,
  input  logic [CNT_W-1:0]    CONF_SETTLE,
  input  logic [CNT_W-1:0]    CONF_DWELL,
  input  logic [TAP_W-1:0]    CUR_DLY,
  input  logic                RX_READY,
  input  logic [7:0]          DECODER_ERR_CNT,
  output logic [TAP_W-1:0]    DLY_VALUE,
  output logic                DLY_LOAD,
  output logic                RX_RST,
  output logic                BUSY,
  output logic                DONE,
  output logic                FAIL,
  output logic [DLY_TAPS-1:0] PASS_MAP,
  output logic [TAP_W-1:0]    BEST_DLY,
  output logic [5:0]          WINDOW_LEN
);

  state_t state, state_nx;

  logic [TAP_W-1:0]    tap;
  logic [TAP_W-1:0]    cur_dly_q;
  logic [TAP_W-1:0]    dly_hold;
  logic [TAP_W-1:0]    best_q;
  logic [TAP_W-1:0]    apply_val;
  logic [TAP_W-1:0]    dly_value;
  logic [5:0]          win_len_q;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    settle_ld;
  logic [CNT_W-1:0]    dwell_ld;
  logic [DLY_TAPS-1:0] pass_map;
  logic                ready_acc;
  logic                tap_pass;
  logic                aborted;
  logic                fail_q;
  logic                last_tap;
  logic                cnt_last;
  logic                accept_start;
  logic                abort_hit;
  logic                err_ok;
  logic                use_window;
  logic                strobe;

  logic                find_start;
  logic                find_bit_valid;
  logic                find_bit;
  logic [TAP_W-1:0]    find_run;
  logic [5:0]          find_len;
  logic                find_valid;

  rx_dly_window_find #(
    .TAPS(DLY_TAPS)
  ) u_window_find (
    .clk      (BUS_CLK),
    .rst      (BUS_RST),
    .start    (find_start),
    .bit_valid(find_bit_valid),
    .bit_in   (find_bit),
    .run_start(find_run),
    .len      (find_len),
    .valid    (find_valid)
  );

  always_comb begin
    last_tap     = (tap == TAP_W'(DLY_TAPS - 1));
    cnt_last     = (cnt == CNT_W'(1));
    settle_ld    = (CONF_SETTLE == '0) ? CNT_W'(1) : CONF_SETTLE;
    dwell_ld     = (CONF_DWELL == '0) ? CNT_W'(1) : CONF_DWELL;
    accept_start = (state == IDLE) && START;
    // A scan already in APPLY/DONE_ST is finishing; abort has nothing left to cancel.
    abort_hit    = ABORT && (state != IDLE) && (state != APPLY) && (state != DONE_ST);
    err_ok       = (DECODER_ERR_CNT != ERR_SAT) && (DECODER_ERR_CNT == '0);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (START) state_nx = LOAD;
      LOAD:    state_nx = SETTLE;
      SETTLE:  if (cnt_last) state_nx = DWELL;
      DWELL:   if (cnt_last) state_nx = EVAL;
      EVAL:    state_nx = last_tap ? SELECT : LOAD;
      SELECT:  if (last_tap) state_nx = APPLY;
      APPLY:   state_nx = DONE_ST;
      DONE_ST: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort_hit) state_nx = APPLY;
  end

  // The finder absorbs its last bit on the SELECT->APPLY edge, so its result
  // is only consumed combinationally during APPLY.
  always_comb begin
    find_start     = (state == EVAL) && (state_nx == SELECT);
    find_bit_valid = (state == SELECT);
    find_bit       = pass_map[tap];
    use_window     = !aborted && find_valid && (find_len != '0);
    apply_val      = use_window ? window_center(find_run, find_len) : cur_dly_q;
    dly_value      = dly_hold;
    if (state == LOAD)  dly_value = tap;
    if (state == APPLY) dly_value = apply_val;
    strobe         = ((state == LOAD) || (state == APPLY)) && !BUS_RST;
  end

  always_comb begin
    DLY_VALUE  = dly_value;
    DLY_LOAD   = strobe;
    RX_RST     = strobe;
    BUSY       = (state != IDLE) && (state != DONE_ST);
    DONE       = (state == DONE_ST) && !BUS_RST;
    FAIL       = fail_q;
    PASS_MAP   = pass_map;
    BEST_DLY   = best_q;
    WINDOW_LEN = win_len_q;
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state     <= IDLE;
      tap       <= '0;
      cnt       <= '0;
      ready_acc <= 1'b0;
      tap_pass  <= 1'b0;
      aborted   <= 1'b0;
      pass_map  <= '0;
      cur_dly_q <= '0;
      dly_hold  <= '0;
      best_q    <= '0;
      win_len_q <= '0;
      fail_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      dly_hold <= dly_value;
      if (accept_start) begin
        tap       <= '0;
        pass_map  <= '0;
        fail_q    <= 1'b0;
        aborted   <= 1'b0;
        cur_dly_q <= CUR_DLY;
      end
      if (abort_hit) aborted <= 1'b1;
      case (state)
        LOAD: cnt <= settle_ld;
        SETTLE: begin
          if (cnt_last) begin
            cnt       <= dwell_ld;
            ready_acc <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DWELL: begin
          ready_acc <= ready_acc & RX_READY;
          if (cnt_last) tap_pass <= ready_acc & RX_READY & err_ok;
          else          cnt      <= cnt - CNT_W'(1);
        end
        EVAL: begin
          pass_map[tap] <= tap_pass;
          tap           <= last_tap ? '0 : tap + TAP_W'(1);
        end
        SELECT: if (!last_tap) tap <= tap + TAP_W'(1);
        APPLY: begin
          best_q    <= apply_val;
          win_len_q <= use_window ? find_len : '0;
          fail_q    <= !use_window;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_dly_scan_ctrl.sv
// Self-checking bench: a behavioural RX core answers each loaded tap from a
// pass pattern; expected scan results are queued at START and popped at DONE.
module tb_rx_dly_scan_ctrl;

  logic        clk = 1'b0;
  logic        BUS_RST, START, ABORT, RX_READY;
  logic [15:0] CONF_SETTLE, CONF_DWELL;
  logic [4:0]  CUR_DLY;
  logic [7:0]  DECODER_ERR_CNT;
  logic [4:0]  DLY_VALUE, BEST_DLY;
  logic        DLY_LOAD, RX_RST, BUSY, DONE, FAIL;
  logic [31:0] PASS_MAP;
  logic [5:0]  WINDOW_LEN;

  rx_dly_scan_ctrl #(.DLY_TAPS(32), .CNT_W(16)) dut (
    .BUS_CLK(clk), .BUS_RST(BUS_RST), .START(START), .ABORT(ABORT),
    .CONF_SETTLE(CONF_SETTLE), .CONF_DWELL(CONF_DWELL), .CUR_DLY(CUR_DLY),
    .RX_READY(RX_READY), .DECODER_ERR_CNT(DECODER_ERR_CNT),
    .DLY_VALUE(DLY_VALUE), .DLY_LOAD(DLY_LOAD), .RX_RST(RX_RST), .BUSY(BUSY),
    .DONE(DONE), .FAIL(FAIL), .PASS_MAP(PASS_MAP), .BEST_DLY(BEST_DLY),
    .WINDOW_LEN(WINDOW_LEN)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pat;
    logic        mode;
    logic [15:0] settle;
    logic [15:0] dwell;
    logic [4:0]  cur;
    logic [31:0] map;
    logic [5:0]  len;
    logic [4:0]  best;
    logic        fail;
  } vec_t;

  typedef struct {
    logic        full;
    logic [31:0] map;
    logic [5:0]  len;
    logic [4:0]  best;
    logic        fail;
    logic [4:0]  final_dly;
    int unsigned loads;
    int unsigned latency;
  } exp_t;

  exp_t        q[$];
  vec_t        vecs[8];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned scan_loads = 0;
  logic [4:0]  last_load = '0;

  logic [31:0] env_pat = '0;
  logic        env_mode = 1'b0;
  logic [4:0]  env_tap = '0;
  int unsigned since = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic int unsigned mx1(input logic [15:0] v);
    return (v == 0) ? 1 : int'(v);
  endfunction

  always @(posedge clk) cyc++;

  // Behavioural RX core: tap 5 saturates the error counter and tap 9 loses
  // lock for one DWELL cycle when env_mode is set.
  always @(negedge clk) begin
    if (DLY_LOAD) begin
      env_tap = DLY_VALUE;
      since   = 0;
    end else begin
      since++;
    end
    RX_READY        = env_pat[env_tap] && !(env_mode && env_tap == 5'd9 && since == 8);
    DECODER_ERR_CNT = (env_mode && env_tap == 5'd5) ? 8'hFF : (env_pat[env_tap] ? 8'h00 : 8'h03);
  end

  always @(negedge clk) begin
    exp_t e;
    if (DLY_LOAD) begin
      chk("rx_rst_with_load", {31'd0, RX_RST}, 32'd1);
      scan_loads++;
      last_load = DLY_VALUE;
    end
    if (DONE) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual 1 required 0");
      end else begin
        e = q.pop_front();
        chk("fail_flag", {31'd0, FAIL}, {31'd0, e.fail});
        chk("final_load_value", {27'd0, last_load}, {27'd0, e.final_dly});
        if (e.full) begin
          chk("pass_map", PASS_MAP, e.map);
          chk("window_len", {26'd0, WINDOW_LEN}, {26'd0, e.len});
          chk("best_dly", {27'd0, BEST_DLY}, {27'd0, e.best});
          chk("load_count", scan_loads, e.loads);
          chk("latency", cyc - start_cyc, e.latency);
        end
      end
    end
  end

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      if (DONE) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual 0 required 1");
    end
  endtask

  task automatic begin_scan(input vec_t v, input logic full);
    exp_t e;
    env_pat     = v.pat;
    env_mode    = v.mode;
    CONF_SETTLE = v.settle;
    CONF_DWELL  = v.dwell;
    CUR_DLY     = v.cur;
    e.full      = full;
    e.map       = v.map;
    e.len       = v.len;
    e.best      = v.best;
    e.fail      = v.fail;
    e.final_dly = v.best;
    e.loads     = 33;
    e.latency   = 32 * (2 + mx1(v.settle) + mx1(v.dwell)) + 34;
    q.push_back(e);
    START      = 1'b1;
    start_cyc  = cyc;
    scan_loads = 0;
    @(posedge clk); #1;
    START = 1'b0;
    chk("busy_after_start", {31'd0, BUSY}, 32'd1);
  endtask

  initial begin
    vec_t va;
    BUS_RST = 1'b1; START = 1'b0; ABORT = 1'b0;
    CONF_SETTLE = 16'd4; CONF_DWELL = 16'd8; CUR_DLY = '0;
    RX_READY = 1'b0; DECODER_ERR_CNT = '0;

    //        pat           mode settle dwell cur  map           len  best fail
    vecs[0] = '{32'hFFFF_FFFF, 1'b0, 16'd4, 16'd8, 5'd3, 32'hFFFF_FFFF, 6'd32, 5'd15, 1'b0};
    vecs[1] = '{32'h001F_FC00, 1'b0, 16'd4, 16'd8, 5'd0, 32'h001F_FC00, 6'd11, 5'd15, 1'b0};
    vecs[2] = '{32'h00F0_0078, 1'b0, 16'd0, 16'd0, 5'd0, 32'h00F0_0078, 6'd4,  5'd4,  1'b0};
    vecs[3] = '{32'h0000_0000, 1'b0, 16'd2, 16'd3, 5'd7, 32'h0000_0000, 6'd0,  5'd7,  1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 1'b1, 16'd4, 16'd8, 5'd0, 32'hFFFF_FDDF, 6'd22, 5'd20, 1'b0};
    vecs[5] = '{32'h8000_0000, 1'b0, 16'd0, 16'd1, 5'd2, 32'h8000_0000, 6'd1,  5'd31, 1'b0};
    vecs[6] = '{32'h8000_0001, 1'b0, 16'd1, 16'd0, 5'd2, 32'h8000_0001, 6'd1,  5'd0,  1'b0};
    vecs[7] = '{32'h7FFF_FFFE, 1'b0, 16'd0, 16'd0, 5'd0, 32'h7FFF_FFFE, 6'd30, 5'd15, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    BUS_RST = 1'b0;
    @(posedge clk); #1;
    chk("rst_dly_load", {31'd0, DLY_LOAD}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_fail", {31'd0, FAIL}, 32'd0);
    chk("rst_pass_map", PASS_MAP, 32'd0);
    chk("rst_dly_value", {27'd0, DLY_VALUE}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      begin_scan(vecs[i], 1'b1);
      wait_done();
      START = 1'b1;
      @(posedge clk); #1;
      START = 1'b0;
      chk("start_in_done_busy", {31'd0, BUSY}, 32'd0);
      chk("start_in_done_load", {31'd0, DLY_LOAD}, 32'd0);
      chk("dly_value_hold", {27'd0, DLY_VALUE}, {27'd0, vecs[i].best});
      repeat (2) @(posedge clk);
      #1;
    end

    // Abort during tap 12 DWELL: next cycle must be APPLY carrying CUR_DLY.
    va = '{32'hFFFF_FFFF, 1'b0, 16'd4, 16'd8, 5'd9, 32'h0, 6'd0, 5'd9, 1'b1};
    begin_scan(va, 1'b0);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 1000 && !hit; i++) begin
        @(posedge clk); #1;
        if (env_tap == 5'd12 && since == 7) hit = 1'b1;
      end
      chk("abort_reached_tap12", {31'd0, hit}, 32'd1);
    end
    ABORT = 1'b1;
    @(posedge clk); #1;
    ABORT = 1'b0;
    chk("abort_apply_load", {31'd0, DLY_LOAD}, 32'd1);
    chk("abort_apply_value", {27'd0, DLY_VALUE}, 32'd9);
    chk("abort_apply_rx_rst", {31'd0, RX_RST}, 32'd1);
    wait_done();
    chk("abort_fail", {31'd0, FAIL}, 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-scan: outputs return to reset values with no strobes.
    env_pat = 32'hFFFF_FFFF; env_mode = 1'b0;
    CONF_SETTLE = 16'd0; CONF_DWELL = 16'd0; CUR_DLY = 5'd5;
    START = 1'b1;
    @(posedge clk); #1;
    START = 1'b0;
    repeat (41) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, BUSY}, 32'd1);
    BUS_RST = 1'b1;
    scan_loads = 0;
    @(posedge clk); #1;
    chk("mid_rst_dly_load", {31'd0, DLY_LOAD}, 32'd0);
    chk("mid_rst_rx_rst", {31'd0, RX_RST}, 32'd0);
    chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("mid_rst_done", {31'd0, DONE}, 32'd0);
    chk("mid_rst_fail", {31'd0, FAIL}, 32'd0);
    chk("mid_rst_pass_map", PASS_MAP, 32'd0);
    chk("mid_rst_best", {27'd0, BEST_DLY}, 32'd0);
    chk("mid_rst_window", {26'd0, WINDOW_LEN}, 32'd0);
    chk("mid_rst_dly_value", {27'd0, DLY_VALUE}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    BUS_RST = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("no_load_after_rst", scan_loads, 32'd0);
    chk("idle_after_rst", {31'd0, BUSY}, 32'd0);
    chk("queue_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
